// File: rtl/fetch_cycle.sv
// fetch_cycle: IF stage with a ready/valid imem request port, a 2-entry instruction buffer and the IF/ID register
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    logic [31:0] pc_f, pc_f_n;
    logic [1:0]  out_cnt, out_cnt_n, out_left, drop_cnt, drop_cnt_n, ibuf_cnt, ibuf_cnt_n;
    logic [31:0] opc [2];
    logic [31:0] buf_pc [2];
    logic [31:0] buf_instr [2];
    logic        accept, drop, live, bubble, load, pop, bypass, push, fill, opc_wr, buf_wr;
    logic [31:0] src_pc, src_instr;

    assign imem_req_valid = rst && !StallF && !PCSrcE && ({1'b0, out_cnt} + {1'b0, ibuf_cnt} < 3'd2);
    assign imem_req_addr  = pc_f;

    always_comb begin
        accept     = imem_req_valid && imem_req_ready;
        drop       = imem_rsp_valid && drop_cnt != 2'd0;
        live       = imem_rsp_valid && drop_cnt == 2'd0 && !PCSrcE;
        bubble     = FlushD || PCSrcE;
        load       = !bubble && !StallD;
        pop        = load && ibuf_cnt != 2'd0;
        bypass     = load && ibuf_cnt == 2'd0 && live;
        push       = live && !bypass;
        fill       = pop || bypass;
        src_pc     = pop ? buf_pc[0] : opc[0];
        src_instr  = pop ? buf_instr[0] : imem_rsp_data;
        // queue write slots are the post-pop occupancy; only the low bit is needed for depth 2
        opc_wr     = out_cnt[0] ^ imem_rsp_valid;
        buf_wr     = ibuf_cnt[0] ^ pop;
        out_left   = out_cnt - {1'b0, imem_rsp_valid};
        pc_f_n     = PCSrcE ? PCTargetE : accept ? pc_f + 32'd4 : pc_f;
        out_cnt_n  = out_left + {1'b0, accept};
        drop_cnt_n = PCSrcE ? out_left : drop ? drop_cnt - 2'd1 : drop_cnt;
        ibuf_cnt_n = PCSrcE ? 2'd0 : ibuf_cnt - {1'b0, pop} + {1'b0, push};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f         <= RESET_PC;
            out_cnt      <= 2'd0;
            drop_cnt     <= 2'd0;
            ibuf_cnt     <= 2'd0;
            opc[0]       <= 32'd0;
            opc[1]       <= 32'd0;
            buf_pc[0]    <= 32'd0;
            buf_pc[1]    <= 32'd0;
            buf_instr[0] <= 32'd0;
            buf_instr[1] <= 32'd0;
            InstrD       <= NOP_INSTR;
            PCD          <= 32'd0;
            PCPlus4D     <= 32'd0;
            ValidD       <= 1'b0;
        end else begin
            pc_f     <= pc_f_n;
            out_cnt  <= out_cnt_n;
            drop_cnt <= drop_cnt_n;
            ibuf_cnt <= ibuf_cnt_n;
            if (imem_rsp_valid)
                opc[0] <= opc[1];
            if (accept)
                opc[opc_wr] <= pc_f;
            if (pop) begin
                buf_pc[0]    <= buf_pc[1];
                buf_instr[0] <= buf_instr[1];
            end
            if (push) begin
                buf_pc[buf_wr]    <= opc[0];
                buf_instr[buf_wr] <= imem_rsp_data;
            end
            // StallD holds IF/ID unless a flush or redirect forces a bubble
            if (bubble || !StallD) begin
                InstrD   <= fill ? src_instr : NOP_INSTR;
                PCD      <= fill ? src_pc : 32'd0;
                PCPlus4D <= fill ? src_pc + 32'd4 : 32'd0;
                ValidD   <= fill;
            end
        end
    end
endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: cycle table plus in-order scoreboard against a variable-latency memory model
module tb_fetch_cycle;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, ValidD;
    logic [31:0] imem_req_addr, imem_rsp_data, InstrD, PCD, PCPlus4D;

    fetch_cycle dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int due;} req_t;
    typedef struct {logic [3:0] ctl; logic [1:0] ex; logic [31:0] addr; logic [31:0] pcd;} vec_t;

    req_t        mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc, shown_p;
    logic        shown_v, prev_hold;
    int          cyc, lat, checks, failures, n;
    vec_t        vecs[22];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ifid_chk(input string tag, input logic v, input logic [31:0] p);
        chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, v});
        chk({tag, "_pcd"}, PCD, v ? p : 32'd0);
        chk({tag, "_instr"}, InstrD, v ? instr_of(p) : NOP);
        chk({tag, "_pc4"}, PCPlus4D, v ? p + 32'd4 : 32'd0);
    endtask

    // One clock cycle: drive at negedge, memory answers in order, sample 1ns later
    task automatic step(input logic sf, input logic sd, input logic fd, input logic pcs,
                        input logic [31:0] tgt, input logic rdy);
        req_t r;
        int   due;
        @(negedge clk);
        rst = 1'b1;
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = pcs; PCTargetE = tgt; imem_req_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].addr);
            mq.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        chk("req_addr", imem_req_addr, exp_pc);
        if (sf || pcs)
            chk("req_gated", {31'd0, imem_req_valid}, 32'd0);
        if (!prev_hold) begin
            if (ValidD === 1'b1 && exp_q.size() > 0) begin
                shown_v = 1'b1;
                shown_p = exp_q.pop_front();
            end else begin
                shown_v = 1'b0;
                shown_p = 32'd0;
            end
        end
        ifid_chk("sb", shown_v, shown_p);
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (mq.size() > 0 && mq[mq.size()-1].due >= due)
                due = mq[mq.size()-1].due + 1;
            r.addr = imem_req_addr;
            r.due  = due;
            mq.push_back(r);
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (pcs) begin
            exp_q.delete();
            exp_pc = tgt;
        end
        prev_hold = sd && !fd && !pcs;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] p);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end while (ValidD !== 1'b1 && n < 30);
        chk({tag, "_seen"}, {31'd0, ValidD}, 32'd1);
        chk({tag, "_pcd"}, PCD, p);
    endtask

    initial begin
        // ctl = {StallF, StallD, FlushD, ready}, ex = {req_valid, ValidD}; latency-1 memory
        vecs[0]  = '{4'b0001, 2'b10, 32'd0,  32'd0};
        vecs[1]  = '{4'b0001, 2'b10, 32'd4,  32'd0};
        vecs[2]  = '{4'b0001, 2'b11, 32'd8,  32'd0};
        vecs[3]  = '{4'b0001, 2'b11, 32'd12, 32'd4};
        vecs[4]  = '{4'b0101, 2'b11, 32'd16, 32'd8};
        vecs[5]  = '{4'b0101, 2'b01, 32'd20, 32'd8};
        vecs[6]  = '{4'b0101, 2'b01, 32'd20, 32'd8};
        vecs[7]  = '{4'b0001, 2'b01, 32'd20, 32'd8};
        vecs[8]  = '{4'b0001, 2'b11, 32'd20, 32'd12};
        vecs[9]  = '{4'b0001, 2'b11, 32'd24, 32'd16};
        vecs[10] = '{4'b0001, 2'b11, 32'd28, 32'd20};
        vecs[11] = '{4'b0000, 2'b11, 32'd32, 32'd24};
        vecs[12] = '{4'b0000, 2'b11, 32'd32, 32'd28};
        vecs[13] = '{4'b0000, 2'b10, 32'd32, 32'd0};
        vecs[14] = '{4'b0000, 2'b10, 32'd32, 32'd0};
        vecs[15] = '{4'b0001, 2'b10, 32'd32, 32'd0};
        vecs[16] = '{4'b0001, 2'b10, 32'd36, 32'd0};
        vecs[17] = '{4'b0001, 2'b11, 32'd40, 32'd32};
        vecs[18] = '{4'b1111, 2'b01, 32'd44, 32'd36};
        vecs[19] = '{4'b0001, 2'b10, 32'd44, 32'd0};
        vecs[20] = '{4'b0001, 2'b11, 32'd48, 32'd40};
        vecs[21] = '{4'b0001, 2'b11, 32'd52, 32'd44};

        checks = 0; failures = 0; cyc = 0; lat = 1;
        exp_pc = 32'd0; shown_v = 1'b0; shown_p = 32'd0; prev_hold = 1'b0;
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'd0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        ifid_chk("reset", 1'b0, 32'd0);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].ctl[1], 1'b0, 32'd0, vecs[i].ctl[0]);
            chk($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].ex[1]});
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].addr);
            ifid_chk($sformatf("vec%0d", i), vecs[i].ex[0], vecs[i].pcd);
        end

        // Redirect with two requests in flight at latency 3, StallD asserted alongside
        lat = 3;
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        ifid_chk("redir_bubble", 1'b0, 32'd0);
        chk("redir_addr", imem_req_addr, 32'h100);
        wait_valid("target", 32'h100);
        wait_valid("target_next", 32'h104);

        // Address wrap at the top of the address space
        lat = 1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_valid("wrap", 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0000_0000);
        wait_valid("wrap_next", 32'h0000_0000);

        // Random mix of stalls, flushes, redirects, backpressure and latency
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 24) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
        end

        lat = 1;
        n = 0;
        while ((exp_q.size() > 0 || mq.size() > 0) && n < 40) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        chk("drain_exp_q", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while instructions are streaming
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("pre_reset_valid", {31'd0, ValidD}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        ifid_chk("async_reset", 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_cycle.md
# fetch_cycle

Instruction-fetch stage of the five-stage pipelined core. It owns the fetch PC and drives a ready/valid request port into instruction memory, which may have variable latency. Returned words go into a 2-entry instruction buffer, and the block produces the IF/ID pipeline register (InstrD, PCD, PCPlus4D) consumed by the decode stage. Stall, flush and branch-redirect controls come from the hazard unit and execute stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, encoding loaded into IF/ID for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- StallF  in  1  inhibit new memory requests; PC holds.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  load bubble into IF/ID.
- PCSrcE  in  1  taken branch/jump redirect from execute.
- PCTargetE  in  32  redirect target.
- imem_req_valid  out  1  request strobe.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word address (PC), sampled on valid&&ready.
- imem_rsp_valid  in  1  response word present, in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation

State:
- PC_F: 32-bit next fetch address.
- out_cnt (0..2): requests accepted but not yet returned.
- drop_cnt (0..2, always ≤ out_cnt): pending responses to discard.
- ibuf: 2-entry FIFO of {pc, instr} with count ibuf_cnt.

Request path:
- imem_req_valid = rst && !StallF && !PCSrcE && (out_cnt + ibuf_cnt < 2), using registered values. imem_req_addr = PC_F.
- There is no hold requirement: valid may drop without acceptance.
- Acceptance (valid && ready) increments PC_F by 4 (mod 2^32 wrap) and increments out_cnt. The PC of each outstanding request is tracked in order.

Response path:
- Each rsp_valid decrements out_cnt.
- If drop_cnt > 0, decrement drop_cnt and discard the word.
- Otherwise the word is live. It bypasses straight to IF/ID when ibuf is empty and IF/ID is loading this cycle; otherwise it is pushed into ibuf.

Redirect (PCSrcE = 1):
- PC_F <= PCTargetE.
- ibuf cleared.
- drop_cnt <= out_cnt − (rsp_valid ? 1 : 0). The response arriving in the redirect cycle is itself discarded.
- No request is issued that cycle.

IF/ID update, in priority order:
1. FlushD or PCSrcE: bubble. InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
2. StallD: hold all IF/ID outputs; ibuf and any live response keep accumulating.
3. ibuf non-empty: pop the head entry into IF/ID (ValidD = 1, PCPlus4D = pc + 4).
4. Live response with ibuf empty: bypass it into IF/ID.
5. Otherwise: bubble.

Pop and push in the same cycle are allowed; FIFO order is preserved. ibuf never overflows because the issue rule bounds out_cnt + ibuf_cnt ≤ 2.

## Timing
- Reset values (asynchronous, while rst = 0):
  - PC_F = RESET_PC; out_cnt = drop_cnt = ibuf_cnt = 0.
  - InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
  - imem_req_valid = 0.
- Reset mid-operation: in-flight responses after reset release are undefined. The memory is reset on the same rst.
- First request: the cycle after rst deasserts, address RESET_PC.
- Latency-1 memory, no stalls: the request accepted in cycle n appears on InstrD after edge n+1. Steady state is one instruction per cycle.
- Redirect asserted in cycle t:
  - IF/ID is a bubble after edge t.
  - Request to PCTargetE is issued in cycle t+1.
  - The target instruction is valid on InstrD after edge t+2 (latency 1), assuming no drops block issue. Pending drops delay issue until out_cnt + ibuf_cnt < 2.
- PCSrcE together with StallD: redirect wins and IF/ID loads a bubble.
- FlushD together with StallD: flush wins.
- StallF alone: no new requests, PC_F holds. Outstanding responses still complete into ibuf/IF/ID.

## Test plan
1. **Reset, then zero-wait memory** (ready = 1, latency 1): requests are issued at 0x0, 0x4, 0x8…; InstrD follows one per cycle with PCD = 0x0, 0x4, 0x8 and ValidD = 1. PCPlus4D = PCD + 4.
2. **StallD for 3 cycles mid-stream:**
   - IF/ID holds its current instruction.
   - ibuf fills to 2 and imem_req_valid drops.
   - After release, the sequence resumes with no lost or duplicated PC.
3. **PCSrcE = 1 with PCTargetE = 0x100 while 2 requests are outstanding (latency 3):**
   - Both responses are discarded and drop_cnt returns to 0.
   - The next valid InstrD has PCD = 0x100 and is followed by 0x104.
4. **imem_req_ready = 0 for 4 cycles:** PC_F holds and IF/ID shows bubbles (ValidD = 0, InstrD = 0x00000013). Fetch resumes at the same address.
5. **FlushD and StallD asserted together, plus StallF:** IF/ID becomes a bubble; with StallF, no request is issued and PC_F is unchanged.
6. **PC wrap:** with RESET_PC = 0xFFFF_FFFC, the fetch after 0xFFFF_FFFC is at 0x0000_0000, and PCPlus4D for the 0xFFFF_FFFC instruction is 0x0000_0000.
